// File: rtl/player_input_ctrl.sv
// Purpose: polls two SNES-style serial pads once per frame and decodes the D-pad into Tron player directions.
// Latency: 2*CLK_HALF + 2*NUM_BITS*CLK_HALF + 1 cycles from frame_tick to commit (busy falling).
// Backpressure: none; a frame_tick that arrives while busy is dropped, not queued. Optional PLAYER_INPUT_DEBOUNCE_EN.
module player_input_ctrl #(
   parameter int CLK_HALF = 300,
   parameter int NUM_BITS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        p1_data,
   input  logic        p2_data,
   output logic        ctrl_latch,
   output logic        ctrl_clk,
   output logic [2:0]  p1_info,
   output logic [2:0]  p2_info,
   output logic [11:0] p1_buttons,
   output logic [11:0] p2_buttons,
   output logic        start_pulse,
   output logic        busy
);

   localparam int CW = $clog2(2*CLK_HALF);
   localparam int IW = $clog2(NUM_BITS);

   localparam logic [CW-1:0] LATCH_LD = CW'(2*CLK_HALF-1);
   localparam logic [CW-1:0] HALF_LD  = CW'(CLK_HALF-1);
   localparam logic [IW-1:0] LAST_BIT = IW'(NUM_BITS-1);
   localparam logic [IW-1:0] BTN_BITS = IW'(12);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LATCH    = 3'd1;
   localparam logic [2:0] S_SHIFT_LO = 3'd2;
   localparam logic [2:0] S_SHIFT_HI = 3'd3;
   localparam logic [2:0] S_COMMIT   = 3'd4;

   localparam logic [2:0] DIR_UP    = 3'b000;
   localparam logic [2:0] DIR_DOWN  = 3'b001;
   localparam logic [2:0] DIR_LEFT  = 3'b010;
   localparam logic [2:0] DIR_RIGHT = 3'b011;
   localparam logic [2:0] DIR_STOP  = 3'b100;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] bit_idx;
   logic [11:0]   sh1, sh2;
   logic          st_prev1, st_prev2;
   logic [3:0]    cand1, cand2;
   logic          ok1, ok2;

   // Candidate from the D-pad bits {right,left,down,up}: {valid, dir}, priority Up > Down > Left > Right.
   function automatic logic [3:0] cand_of(input logic [3:0] dpad);
      logic [3:0] c;
      c = {1'b0, DIR_STOP};
      if (dpad[0])      c = {1'b1, DIR_UP};
      else if (dpad[1]) c = {1'b1, DIR_DOWN};
      else if (dpad[2]) c = {1'b1, DIR_LEFT};
      else if (dpad[3]) c = {1'b1, DIR_RIGHT};
      return c;
   endfunction

   // Apply a candidate to the current direction; reversals and empty D-pad hold the current direction.
   function automatic logic [2:0] steer(input logic [2:0] cur, input logic [3:0] cand, input logic ok);
      logic [2:0] nxt;
      nxt = cur;
      if (cand[3] && ok) begin
         if (cur == DIR_STOP)
            nxt = cand[2:0];
         else if (!(cand[1] == cur[1] && cand[0] != cur[0]))
            nxt = cand[2:0];
      end
      return nxt;
   endfunction

   assign busy        = (state != S_IDLE);
   assign ctrl_latch  = (state == S_LATCH);
   assign ctrl_clk    = (state != S_SHIFT_LO);
   assign cand1       = cand_of(sh1[7:4]);
   assign cand2       = cand_of(sh2[7:4]);
   assign start_pulse = (state == S_COMMIT) &&
                        ((sh1[3] && !st_prev1) || (sh2[3] && !st_prev2));

`ifdef PLAYER_INPUT_DEBOUNCE_EN
   logic [3:0] pc1, pc2;

   // A direction change needs the same candidate on two consecutive polls.
   assign ok1 = (cand1 == pc1);
   assign ok2 = (cand2 == pc2);

   // Remember each poll's candidate for the next comparison.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc1 <= {1'b0, DIR_STOP};
         pc2 <= {1'b0, DIR_STOP};
      end else if (state == S_COMMIT) begin
         pc1 <= cand1;
         pc2 <= cand2;
      end
   end
`else
   assign ok1 = 1'b1;
   assign ok2 = 1'b1;
`endif

   // Poll sequencer: latch pulse, then NUM_BITS low/high serial clock phases, then one commit cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh1     <= '0;
         sh2     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  state <= S_LATCH;
                  cnt   <= LATCH_LD;
               end
            end
            S_LATCH: begin
               if (cnt == '0) begin
                  state   <= S_SHIFT_LO;
                  cnt     <= HALF_LD;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_SHIFT_LO: begin
               if (cnt == '0) begin
                  state <= S_SHIFT_HI;
                  cnt   <= HALF_LD;
                  // Shift in from the top so bit i lands at position i after 12 samples; bits 12+ are discarded.
                  if (bit_idx < BTN_BITS) begin
                     sh1 <= {~p1_data, sh1[11:1]};
                     sh2 <= {~p2_data, sh2[11:1]};
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_SHIFT_HI: begin
               if (cnt == '0) begin
                  if (bit_idx == LAST_BIT) begin
                     state <= S_COMMIT;
                  end else begin
                     state   <= S_SHIFT_LO;
                     cnt     <= HALF_LD;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_COMMIT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Commit buttons, directions and Start history once per completed poll.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p1_info    <= DIR_STOP;
         p2_info    <= DIR_STOP;
         p1_buttons <= '0;
         p2_buttons <= '0;
         st_prev1   <= 1'b0;
         st_prev2   <= 1'b0;
      end else if (state == S_COMMIT) begin
         p1_info    <= steer(p1_info, cand1, ok1);
         p2_info    <= steer(p2_info, cand2, ok2);
         p1_buttons <= sh1;
         p2_buttons <= sh2;
         st_prev1   <= sh1[3];
         st_prev2   <= sh2[3];
      end
   end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Purpose: scoreboard bench for player_input_ctrl with a serial-controller model on each data line.
// Latency: expects commit 10201 cycles after frame_tick (CLK_HALF=300, NUM_BITS=16).
// Backpressure: checks that frame_tick during a poll is ignored.
module tb_player_input_ctrl;

   localparam logic [2:0] UP = 3'b000, DOWN = 3'b001, LEFT = 3'b010, RIGHT = 3'b011, STOP = 3'b100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        frame_tick = 1'b0;
   logic        p1_data, p2_data;
   logic        ctrl_latch, ctrl_clk, start_pulse, busy;
   logic [2:0]  p1_info, p2_info;
   logic [11:0] p1_buttons, p2_buttons;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   player_input_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .p1_data     (p1_data),
      .p2_data     (p2_data),
      .ctrl_latch  (ctrl_latch),
      .ctrl_clk    (ctrl_clk),
      .p1_info     (p1_info),
      .p2_info     (p2_info),
      .p1_buttons  (p1_buttons),
      .p2_buttons  (p2_buttons),
      .start_pulse (start_pulse),
      .busy        (busy)
   );

   // Controller model: latch reloads bit 0, each rising serial clock advances one bit, past bit 15 reads 1.
   logic [15:0] w1 = 16'hFFFF, w2 = 16'hFFFF;
   int          sidx = 0;
   logic        prev_cclk = 1'b1;

   always @(posedge clock) begin
      if (ctrl_latch) sidx <= 0;
      else if (ctrl_clk && !prev_cclk) sidx <= sidx + 1;
      prev_cclk <= ctrl_clk;
   end

   assign p1_data = (sidx < 16) ? w1[sidx[3:0]] : 1'b1;
   assign p2_data = (sidx < 16) ? w2[sidx[3:0]] : 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state.
   typedef struct {
      logic [2:0]  i1, i2;
      logic [11:0] b1, b2;
      int          starts;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] m1 = STOP, m2 = STOP;
   logic       ms1 = 1'b0, ms2 = 1'b0;
   logic [3:0] mc1 = 4'h4, mc2 = 4'h4;

   function automatic logic [3:0] m_cand(input logic [11:0] p);
      if (p[4]) return {1'b1, UP};
      if (p[5]) return {1'b1, DOWN};
      if (p[6]) return {1'b1, LEFT};
      if (p[7]) return {1'b1, RIGHT};
      return {1'b0, STOP};
   endfunction

   function automatic logic [2:0] m_next(input logic [2:0] cur, input logic [3:0] c4, input logic stable);
      logic [2:0] c;
      c = c4[2:0];
      if (!c4[3] || !stable) return cur;
      if (cur == STOP) return c;
      if ((cur == UP && c == DOWN) || (cur == DOWN && c == UP) ||
          (cur == LEFT && c == RIGHT) || (cur == RIGHT && c == LEFT)) return cur;
      return c;
   endfunction

   task automatic model_step(input logic [11:0] pr1, input logic [11:0] pr2);
      exp_t       e;
      logic [3:0] c1, c2;
      logic       s1, s2;
      c1 = m_cand(pr1);
      c2 = m_cand(pr2);
`ifdef PLAYER_INPUT_DEBOUNCE_EN
      s1 = (c1 == mc1);
      s2 = (c2 == mc2);
`else
      s1 = 1'b1;
      s2 = 1'b1;
`endif
      m1 = m_next(m1, c1, s1);
      m2 = m_next(m2, c2, s2);
      mc1 = c1;
      mc2 = c2;
      e.i1 = m1;
      e.i2 = m2;
      e.b1 = pr1;
      e.b2 = pr2;
      e.starts = ((pr1[3] && !ms1) || (pr2[3] && !ms2)) ? 1 : 0;
      ms1 = pr1[3];
      ms2 = pr2[3];
      sb.push_back(e);
   endtask

   // One full poll: pressed masks are active-high, bits 0..11.
   task automatic do_poll(input logic [11:0] pr1, input logic [11:0] pr2, input bit mid_tick, input string tag);
      int   n, lat, falls, rises, st;
      logic pc;
      exp_t e;
      w1 = {4'hF, ~pr1};
      w2 = {4'hF, ~pr2};
      model_step(pr1, pr2);
      @(negedge clock) frame_tick = 1'b1;
      @(negedge clock) frame_tick = 1'b0;
      n = 0; lat = 0; falls = 0; rises = 0; st = 0; pc = 1'b1;
      while (busy && n < 12000) begin
         if (ctrl_latch) lat++;
         if (pc && !ctrl_clk) falls++;
         if (!pc && ctrl_clk) rises++;
         pc = ctrl_clk;
         if (start_pulse) st++;
         frame_tick = (mid_tick && n == 100);
         @(negedge clock);
         n++;
      end
      frame_tick = 1'b0;
      chk({tag, "_len"},      n,     10201);
      chk({tag, "_latch"},    lat,   600);
      chk({tag, "_clk_lo"},   falls, 16);
      chk({tag, "_clk_hi"},   rises, 16);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_p1_info"}, 32'(p1_info),    32'(e.i1));
         chk({tag, "_p2_info"}, 32'(p2_info),    32'(e.i2));
         chk({tag, "_p1_btn"},  32'(p1_buttons), 32'(e.b1));
         chk({tag, "_p2_btn"},  32'(p2_buttons), 32'(e.b2));
         chk({tag, "_start"},   st,              e.starts);
      end
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_latch", 32'(ctrl_latch),  0);
      chk("rst_cclk",  32'(ctrl_clk),    1);
      chk("rst_busy",  32'(busy),        0);
      chk("rst_start", 32'(start_pulse), 0);
      chk("rst_p1",    32'(p1_info),     32'(STOP));
      chk("rst_p2",    32'(p2_info),     32'(STOP));
      chk("rst_b1",    32'(p1_buttons),  0);
      chk("rst_b2",    32'(p2_buttons),  0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Idle pads, with a stray frame_tick 100 cycles in.
      do_poll(12'h000, 12'h000, 1'b1, "idle");
      // p1 Right, p2 Up + Start.
      do_poll(12'h080, 12'h018, 1'b0, "right_up");
      // p1 Left only (reversal), p2 Start held.
      do_poll(12'h040, 12'h008, 1'b0, "rev");
      // p1 Up + Left (Up wins), p2 Start held.
      do_poll(12'h050, 12'h008, 1'b0, "upleft");

      // Reset in the middle of bit 5's low phase.
      w1 = {4'hF, ~12'h020};
      w2 = 16'hFFFF;
      @(negedge clock) frame_tick = 1'b1;
      @(negedge clock) frame_tick = 1'b0;
      repeat (3699) @(negedge clock);
      chk("mid_cclk_low", 32'(ctrl_clk), 0);
      reset = 1'b0;
      #1;
      chk("abort_cclk",  32'(ctrl_clk),    1);
      chk("abort_latch", 32'(ctrl_latch),  0);
      chk("abort_busy",  32'(busy),        0);
      chk("abort_p1",    32'(p1_info),     32'(STOP));
      chk("abort_p2",    32'(p2_info),     32'(STOP));
      chk("abort_b1",    32'(p1_buttons),  0);
      chk("abort_b2",    32'(p2_buttons),  0);
      chk("abort_start", 32'(start_pulse), 0);
      m1 = STOP; m2 = STOP; ms1 = 1'b0; ms2 = 1'b0; mc1 = 4'h4; mc2 = 4'h4;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Down on two consecutive polls after the abort.
      do_poll(12'h020, 12'h000, 1'b0, "down1");
      do_poll(12'h020, 12'h000, 1'b0, "down2");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Front end of the Tron game. Polls two SNES-style serial controllers once per video frame.
- Decodes each controller's D-pad into a player_dir_t direction. The no-reverse rule is applied at this stage.
- Drives p1_info/p2_info, which are consumed by the draw/update logic.
- Also reports raw button state and a start-game pulse.

Parameters:
CLK_HALF, 300, system clocks per half serial period (6 us at 50 MHz); latch-high time is 2*CLK_HALF
NUM_BITS, 16, serial bits shifted per poll (bits 12..15 unused, read back 1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
frame_tick  input  1  one-cycle pulse at end of frame (row 599, col 799); starts a poll
p1_data  input  1  controller 1 serial data, active-low (0 = pressed)
p2_data  input  1  controller 2 serial data, active-low
ctrl_latch  output  1  shared latch to both controllers, active-high
ctrl_clk  output  1  shared serial clock, idles high
p1_info  output  3  player 1 direction: UP=000 DOWN=001 LEFT=010 RIGHT=011 STOP=100
p2_info  output  3  player 2 direction, same encoding
p1_buttons  output  12  player 1 buttons, active-high, bit i = serial bit i
p2_buttons  output  12  player 2 buttons
start_pulse  output  1  one-cycle pulse: Start newly pressed on either controller
busy  output  1  poll in progress

Behaviour:
- Reset (reset=0, async) values:
  - ctrl_latch=0, ctrl_clk=1, busy=0, start_pulse=0.
  - p1_info=p2_info=STOP.
  - buttons=0; shift registers cleared; FSM=IDLE.
  - Reset mid-poll aborts the transfer immediately. No partial data is committed.
- FSM states: IDLE, LATCH, SHIFT_LO, SHIFT_HI, COMMIT.
  - IDLE: on frame_tick go to LATCH and set busy=1. frame_tick while busy is ignored and not queued.
  - LATCH: ctrl_latch=1 for 2*CLK_HALF cycles, then drop it and go to SHIFT_LO with bit index 0.
  - SHIFT_LO: ctrl_clk=0 for CLK_HALF cycles. On the last cycle, sample ~p1_data/~p2_data into bit[index].
  - SHIFT_HI: ctrl_clk=1 for CLK_HALF cycles. If index==NUM_BITS-1, go to COMMIT; else index+1 and go to SHIFT_LO.
  - COMMIT: one cycle. Update buttons and directions, assert start_pulse if applicable. Then go to IDLE with busy=0.
  - Poll length: 2*CLK_HALF + 2*NUM_BITS*CLK_HALF + 1 cycles from the frame_tick cycle to busy falling.
- Serial bit map: 0=B, 1=Y, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right, 8=A, 9=X, 10=L, 11=R.
- Direction decode (per player, COMMIT only):
  - Candidate is the first pressed in priority order Up > Down > Left > Right.
  - No D-pad pressed: hold the current direction. STOP is never produced by releasing.
  - Candidate opposite to the current direction (UP/DOWN, LEFT/RIGHT): ignore it and hold the current direction.
  - From STOP, any candidate is accepted.
  - Outputs change only in the COMMIT cycle, so there is at most one change per frame.
- start_pulse: asserted in COMMIT when Start is pressed now (either player) and was not pressed in the previous commit on that same player.
- Counters are sized to $clog2(2*CLK_HALF) bits and reload on each state entry. CLK_HALF >= 2 is required.
- p1 and p2 are decoded independently and committed in the same cycle.

Optional Feature:
- Macro: PLAYER_INPUT_DEBOUNCE_EN.
- When defined: a new candidate direction takes effect only if it equals the candidate decoded in the previous poll for that player. This requires 2 consecutive frames, so the minimum change latency is 2 polls. The reversal rule still applies.
- When undefined: the candidate is applied on the first poll.

Test Plan:
- Reset, then one frame_tick with both data lines held 1:
  - ctrl_latch high exactly 600 cycles (CLK_HALF=300).
  - 16 low and 16 high ctrl_clk phases.
  - busy drops at cycle 10201.
  - p1_info=p2_info=100; start_pulse never asserted.
- p1_data drives bit 7 low (Right), p2 bit 4 low (Up) -> after COMMIT: p1_info=011, p2_info=000, p1_buttons=12'h080, p2_buttons=12'h010.
- p1 at RIGHT (011), next poll presses Left only (bit 6) -> p1_info stays 011. Following poll presses Up+Left (bits 4,6) -> p1_info=000.
- Start (bit 3) held on p2 across 3 polls -> start_pulse high exactly 1 cycle, only at the first COMMIT.
- frame_tick pulsed 100 cycles into a poll -> ignored: no restart, total poll still 10201 cycles. Reset asserted at SHIFT bit 5 -> outputs return to reset values, ctrl_clk=1 immediately.
- With PLAYER_INPUT_DEBOUNCE_EN, p1 presses Down for one poll then releases -> p1_info stays 100. Down held 2 polls -> 001 at second COMMIT.
